// File: rtl/tx_traffic_gen.sv
// tx_traffic_gen
//   Stimulus engine for the TX path (main FIFO -> VC0/VC1 -> destination FIFOs).
//   A run programs every FIFO threshold while holding init high. It then pushes a
//   seeded LFSR word stream into the main FIFO and backs off on MAIN_PAUSE.
//   Alongside the pushes it issues round-robin pops to the destination FIFOs.
//   After a fixed pop-only drain window it reports done with push/pop counts.
//
// Ports
//   clk, RESET        : rising-edge clock, synchronous active-high reset
//   start             : level; begins a run when seen in IDLE or DONE
//   MAIN_PAUSE        : main FIFO almost-full back-pressure
//   pop_mask          : 1 = destination skipped by the pop arbiter
//   init              : high while thresholds are being programmed
//   PUSH_MAIN         : push strobe to the main FIFO, with DATA_IN_TX
//   POP_D             : one-hot pop pulses to the destination FIFOs
//   *_low / *_high    : FIFO threshold fields (d_low/d_high packed, field i = dest i)
//   pkt_count         : pushes issued this run
//   pop_count         : pops issued this run (saturating)
//   done              : run complete
//
// Handshake: PUSH_MAIN and POP_D are single-cycle strobes with no ready. Flow
// control is MAIN_PAUSE only. It is sampled in the cycle it is seen, so one push
// already scheduled may still land after it rises.
module tx_traffic_gen #(
  parameter int DATA_W       = 6,
  parameter int NUM_DEST     = 2,
  parameter int TH_W         = 5,
  parameter int NUM_PKTS     = 8,
  parameter int PUSH_GAP     = 3,
  parameter int POP_PERIOD   = 6,
  parameter int CFG_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 32,
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(6'b001010),
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(6'b110000),
  parameter int MAIN_LOW     = 1,
  parameter int MAIN_HIGH    = 3,
  parameter int VC_LOW       = 3,
  parameter int VC_HIGH      = 12,
  parameter int D_LOW        = 1,
  parameter int D_HIGH       = 3,
  localparam int PC_W        = $clog2(NUM_PKTS + 1)
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     start,
  input  logic                     MAIN_PAUSE,
  input  logic [NUM_DEST-1:0]      pop_mask,
  output logic                     init,
  output logic                     PUSH_MAIN,
  output logic [DATA_W-1:0]        DATA_IN_TX,
  output logic [NUM_DEST-1:0]      POP_D,
  output logic [TH_W-1:0]          main_fifo_low,
  output logic [TH_W-1:0]          main_fifo_high,
  output logic [TH_W-1:0]          vc0_low,
  output logic [TH_W-1:0]          vc0_high,
  output logic [TH_W-1:0]          vc1_low,
  output logic [TH_W-1:0]          vc1_high,
  output logic [NUM_DEST*TH_W-1:0] d_low,
  output logic [NUM_DEST*TH_W-1:0] d_high,
  output logic [PC_W-1:0]          pkt_count,
  output logic [15:0]              pop_count,
  output logic                     done
);

  localparam int PH_MAX = (CFG_CYCLES > DRAIN_CYCLES) ? CFG_CYCLES : DRAIN_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int GAP_W  = (PUSH_GAP > 0) ? $clog2(PUSH_GAP + 1) : 1;
  localparam int PT_W   = (POP_PERIOD > 1) ? $clog2(POP_PERIOD) : 1;
  localparam int RR_W   = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [DATA_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? DATA_W'(1) : LFSR_SEED;
  localparam logic [PH_W-1:0]   CFG_LAST = PH_W'(CFG_CYCLES - 1);
  localparam logic [PH_W-1:0]   DRN_LAST = PH_W'(DRAIN_CYCLES - 1);
  localparam logic [PT_W-1:0]   PT_LOAD  = PT_W'(POP_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [PH_W-1:0]          ph_q, ph_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [PT_W-1:0]          ptim_q, ptim_d;
  logic [RR_W-1:0]          rr_q, rr_d;
  logic [DATA_W-1:0]        lfsr_q, lfsr_d;
  logic                     init_q, init_d;
  logic                     push_q, push_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [NUM_DEST-1:0]      pop_q, pop_d;
  logic [TH_W-1:0]          mlo_q, mlo_d, mhi_q, mhi_d;
  logic [TH_W-1:0]          v0lo_q, v0lo_d, v0hi_q, v0hi_d;
  logic [TH_W-1:0]          v1lo_q, v1lo_d, v1hi_q, v1hi_d;
  logic [NUM_DEST*TH_W-1:0] dlo_q, dlo_d, dhi_q, dhi_d;
  logic [PC_W-1:0]          pkt_q, pkt_d;
  logic [15:0]              popc_q, popc_d;
  logic                     done_q, done_d;

  // Round-robin pick: first unmasked destination at or above rr, otherwise
  // wrap to the lowest unmasked one below rr.
  logic            pick_found;
  logic [RR_W-1:0] pick_sel;

  always_comb begin
    pick_found = 1'b0;
    pick_sel   = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (!pick_found && !pop_mask[i] && (RR_W'(i) >= rr_q)) begin
        pick_found = 1'b1;
        pick_sel   = RR_W'(i);
      end
    end
    for (int i = 0; i < NUM_DEST; i++) begin
      if (!pick_found && !pop_mask[i]) begin
        pick_found = 1'b1;
        pick_sel   = RR_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    gap_d   = gap_q;
    ptim_d  = ptim_q;
    rr_d    = rr_q;
    lfsr_d  = lfsr_q;
    push_d  = 1'b0;
    data_d  = data_q;
    pop_d   = '0;
    mlo_d   = mlo_q;
    mhi_d   = mhi_q;
    v0lo_d  = v0lo_q;
    v0hi_d  = v0hi_q;
    v1lo_d  = v1lo_q;
    v1hi_d  = v1hi_q;
    dlo_d   = dlo_q;
    dhi_d   = dhi_q;
    pkt_d   = pkt_q;
    popc_d  = popc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CONFIG;
          ph_d    = '0;
        end
      end
      S_CONFIG: begin
        if (ph_q == CFG_LAST) begin
          state_d = S_RUN;
          pkt_d   = '0;
          popc_d  = '0;
          lfsr_d  = SEED_EFF;
          gap_d   = '0;
          ptim_d  = PT_LOAD;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_RUN: begin
        // Leave only once the last push strobe has been seen on the output.
        if ((pkt_q == PC_W'(NUM_PKTS)) && !push_q) begin
          state_d = S_DRAIN;
          ph_d    = '0;
        end else if ((pkt_q < PC_W'(NUM_PKTS)) && (gap_q == '0) && !MAIN_PAUSE) begin
          push_d = 1'b1;
          data_d = lfsr_q;
          pkt_d  = pkt_q + 1'b1;
          gap_d  = GAP_W'(PUSH_GAP);
          lfsr_d = {lfsr_q[DATA_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end else if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (ph_q == DRN_LAST) begin
          state_d = S_DONE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
      if (ptim_q == '0) begin
        ptim_d = PT_LOAD;
        if (pick_found) begin
          pop_d  = NUM_DEST'(1) << pick_sel;
          rr_d   = (pick_sel == RR_W'(NUM_DEST - 1)) ? '0 : pick_sel + 1'b1;
          popc_d = (popc_q == 16'hFFFF) ? popc_q : popc_q + 16'd1;
        end
      end else begin
        ptim_d = ptim_q - 1'b1;
      end
    end

    // Thresholds are loaded as CONFIG is entered so they show on its first cycle.
    if ((state_d == S_CONFIG) && (state_q != S_CONFIG)) begin
      mlo_d  = TH_W'(MAIN_LOW);
      mhi_d  = TH_W'(MAIN_HIGH);
      v0lo_d = TH_W'(VC_LOW);
      v0hi_d = TH_W'(VC_HIGH);
      v1lo_d = TH_W'(VC_LOW);
      v1hi_d = TH_W'(VC_HIGH);
      dlo_d  = {NUM_DEST{TH_W'(D_LOW)}};
      dhi_d  = {NUM_DEST{TH_W'(D_HIGH)}};
    end

    init_d = (state_d == S_CONFIG);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      gap_q   <= '0;
      ptim_q  <= '0;
      rr_q    <= '0;
      lfsr_q  <= SEED_EFF;
      init_q  <= 1'b0;
      push_q  <= 1'b0;
      data_q  <= '0;
      pop_q   <= '0;
      mlo_q   <= '0;
      mhi_q   <= '0;
      v0lo_q  <= '0;
      v0hi_q  <= '0;
      v1lo_q  <= '0;
      v1hi_q  <= '0;
      dlo_q   <= '0;
      dhi_q   <= '0;
      pkt_q   <= '0;
      popc_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      gap_q   <= gap_d;
      ptim_q  <= ptim_d;
      rr_q    <= rr_d;
      lfsr_q  <= lfsr_d;
      init_q  <= init_d;
      push_q  <= push_d;
      data_q  <= data_d;
      pop_q   <= pop_d;
      mlo_q   <= mlo_d;
      mhi_q   <= mhi_d;
      v0lo_q  <= v0lo_d;
      v0hi_q  <= v0hi_d;
      v1lo_q  <= v1lo_d;
      v1hi_q  <= v1hi_d;
      dlo_q   <= dlo_d;
      dhi_q   <= dhi_d;
      pkt_q   <= pkt_d;
      popc_q  <= popc_d;
      done_q  <= done_d;
    end
  end

  assign init           = init_q;
  assign PUSH_MAIN      = push_q;
  assign DATA_IN_TX     = data_q;
  assign POP_D          = pop_q;
  assign main_fifo_low  = mlo_q;
  assign main_fifo_high = mhi_q;
  assign vc0_low        = v0lo_q;
  assign vc0_high       = v0hi_q;
  assign vc1_low        = v1lo_q;
  assign vc1_high       = v1hi_q;
  assign d_low          = dlo_q;
  assign d_high         = dhi_q;
  assign pkt_count      = pkt_q;
  assign pop_count      = popc_q;
  assign done           = done_q;

endmodule

// File: doc/tx_traffic_gen.md
Name: tx_traffic_gen

Overview:
- Synthesizable, parametrised stimulus engine for the TX path (main FIFO → VC0/VC1 → D0..Dn-1 FIFOs).
- Programs all FIFO almost-empty/almost-full thresholds and pulses init.
- Pushes a seeded LFSR word stream into the main FIFO, honouring MAIN_PAUSE.
- Issues round-robin pops on N destination FIFOs, then drains and reports done with counts.

Parameters:
DATA_W, 6, width of DATA_IN_TX and LFSR
NUM_DEST, 2, number of destination FIFOs / POP_D bits
TH_W, 5, width of each threshold field
NUM_PKTS, 8, words pushed per run
PUSH_GAP, 3, minimum idle cycles between successive pushes
POP_PERIOD, 6, cycles between pop pulses
CFG_CYCLES, 2, cycles init is held high
DRAIN_CYCLES, 32, pop-only cycles after the last push
LFSR_SEED, 6'b001010, first data word (0 is replaced by 1)
LFSR_TAPS, 6'b110000, Fibonacci feedback mask (x^6+x^5+1)
MAIN_LOW/MAIN_HIGH, 1/3, main FIFO thresholds
VC_LOW/VC_HIGH, 3/12, VC0 and VC1 thresholds
D_LOW/D_HIGH, 1/3, destination FIFO thresholds (all destinations)

Ports:
clk  in  1  clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
start  in  1  level; sampled in IDLE or DONE to begin a run
MAIN_PAUSE  in  1  main FIFO almost-full back-pressure
pop_mask  in  NUM_DEST  1 = destination skipped by pop arbiter
init  out  1  high during CONFIG
PUSH_MAIN  out  1  push strobe to main FIFO
DATA_IN_TX  out  DATA_W  push data
POP_D  out  NUM_DEST  one-hot pop pulses
main_fifo_low, main_fifo_high  out  TH_W each
vc0_low, vc0_high, vc1_low, vc1_high  out  TH_W each
d_low, d_high  out  NUM_DEST*TH_W  packed; field i = destination i
pkt_count  out  clog2(NUM_PKTS+1)  pushes issued this run
pop_count  out  16  pops issued this run (saturates at 0xFFFF)
done  out  1  run complete

Behaviour:
- All outputs are registered.
- On reset, every output is 0, the FSM goes to IDLE, the LFSR is loaded with the seed, rr = 0, and both timers are 0.
- Reset takes priority in any state, including mid-run.

FSM: IDLE → CONFIG → RUN → DRAIN → DONE.
- IDLE: when start=1, go to CONFIG.
- CONFIG:
  - Lasts CFG_CYCLES cycles with init=1.
  - All threshold outputs load their parameter values on the first CONFIG cycle and hold until reset.
  - On exit: pkt_count=0, pop_count=0, LFSR=seed, gap=0, pop_timer=POP_PERIOD-1.
- RUN: when pkt_count==NUM_PKTS and PUSH_MAIN=0, go to DRAIN.
- DRAIN: after DRAIN_CYCLES cycles, go to DONE.
- DONE:
  - done=1 holds; counts hold.
  - When start=1, go to CONFIG (done clears on entry).

Push rule (RUN only):
- PUSH_MAIN_next = (pkt_count < NUM_PKTS) & (gap == 0) & ~MAIN_PAUSE.
- MAIN_PAUSE is sampled in the same cycle, so there is one-cycle latency and at most one push can land after pause rises.
- First possible PUSH_MAIN is the cycle after RUN entry.
- Each cycle PUSH_MAIN=1 counts as one push:
  - DATA_IN_TX holds the current LFSR value.
  - pkt_count increments.
  - The LFSR advances the next cycle.
  - gap loads PUSH_GAP.
- gap decrements to 0 every cycle; pause does not reload it.
- PUSH_MAIN is a single-cycle pulse when PUSH_GAP ≥ 1. With PUSH_GAP=0, back-to-back pushes are allowed.
- DATA_IN_TX holds its last value while idle.

Pop rule (RUN and DRAIN):
- pop_timer decrements each cycle.
- At 0 it reloads POP_PERIOD-1 and pops the first unmasked destination at or after rr (cyclic search).
  - POP_D[i] is high for exactly one cycle.
  - rr becomes i+1 mod NUM_DEST.
  - pop_count increments.
- If all destinations are masked: no pop, rr unchanged.
- Pops and pushes may coincide.

Test Plan:
- Defaults, start=1 then 0, MAIN_PAUSE=0 → init high 2 cycles; thresholds 1/3/3/12/3/12/1/3; first push 0x0A; pushes spaced 4 cycles apart; 8 pushes total; done=1; pkt_count=8.
- LFSR check → pushed sequence is 0x0A, then each next word equals {prev[4:0], prev[5]^prev[4]}; no 0x00 ever appears.
- MAIN_PAUSE held high 10 cycles starting on the cycle of the 2nd push → at most 1 extra push during pause; PUSH_MAIN resumes 1 cycle after pause falls; total still 8.
- pop_mask=0 → POP_D sequence 01,10,01,10 every 6 cycles; pop_mask=2'b01 → only POP_D=10; pop_mask=2'b11 → no pops, pop_count=0.
- RESET asserted mid-RUN after 3 pushes → next cycle all outputs 0, state IDLE; restart repeats the sequence from 0x0A.
- Start held high in DONE → new run begins; done clears on the CONFIG entry cycle; counts restart from 0.
